dma_tile_sequencer: RTL and testbench
=====================================

DMA_TILE_SEQUENCER -- requirements
Module: dma_tile_sequencer

Interface
REQ-001 SHALL have parameter DMA_AXI_ADDR_WIDTH, default 32, address width of base/stride/command address.
REQ-002 SHALL have parameter DMA_DATA_WIDTH_SRC, default 64, read beat width in bits; BEAT_BYTES = DMA_DATA_WIDTH_SRC/8, a power of two.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum issued-but-incomplete bursts.
REQ-004 m_axi_aclk  input  1  clock; all logic on rising edge.
REQ-005 m_axi_aresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 tile_valid  input  1  tile descriptor valid.
REQ-007 tile_ready  output  1  descriptor accepted when tile_valid & tile_ready.
REQ-008 tile_base  input  DMA_AXI_ADDR_WIDTH  first-row byte address.
REQ-009 tile_row_bytes  input  16  bytes per row.
REQ-010 tile_rows  input  16  row count.
REQ-011 tile_stride  input  DMA_AXI_ADDR_WIDTH  byte offset between row starts.
REQ-012 cmd_valid  output  1  burst command valid.
REQ-013 cmd_ready  input  1  DMA accepts command.
REQ-014 cmd_addr  output  DMA_AXI_ADDR_WIDTH  burst start address.
REQ-015 cmd_len  output  8  beats minus one (AXI4 arlen encoding).
REQ-016 cmd_size  output  3  log2(BEAT_BYTES), constant.
REQ-017 cmd_last  output  1  command is final burst of tile.
REQ-018 burst_done  input  1  one-cycle pulse per completed burst (rlast handshake).
REQ-019 abort  input  1  level; stop issuing for current tile.
REQ-020 busy  output  1  high from descriptor acceptance to tile_done.
REQ-021 tile_done  output  1  one-cycle pulse, tile finished or aborted.
REQ-022 tile_aborted  output  1  valid with tile_done; 1 if ended by abort.
REQ-023 cfg_err  output  1  one-cycle pulse on rejected descriptor.

Function
REQ-024 FSM states IDLE, CHECK, ISSUE, DRAIN; tile_ready=1 only in IDLE.
REQ-025 IDLE->CHECK on descriptor handshake; base, row_bytes, rows, stride registered.
REQ-026 CHECK: row_bytes==0, rows==0, row_bytes not multiple of BEAT_BYTES, or base not BEAT_BYTES-aligned -> cfg_err pulse, return IDLE, no command, no tile_done; else ->ISSUE.
REQ-027 Burst beats = min(remaining row beats, 256, beats to next 4 KB boundary from cmd_addr).
REQ-028 Bursts never cross a 4 KB address boundary.
REQ-029 cmd_valid in ISSUE only while outstanding < MAX_OUTSTANDING; cmd fields stable while cmd_valid & !cmd_ready; cmd_valid never drops without handshake.
REQ-030 On handshake: address advances by beats*BEAT_BYTES; row exhausted -> next row at row_start+stride, modulo 2^DMA_AXI_ADDR_WIDTH.
REQ-031 First command valid no later than 2 cycles after CHECK entry; back-to-back commands allowed every cycle.
REQ-032 cmd_last=1 only on final burst of final row; after its handshake ->DRAIN.
REQ-033 Outstanding counter: +1 on cmd handshake, -1 on burst_done, unchanged when both same cycle; burst_done at zero ignored.
REQ-034 DRAIN: when outstanding==0, tile_done pulse, ->IDLE next cycle.
REQ-035 abort in ISSUE: no new cmd_valid; pending cmd_valid held until handshake; then ->DRAIN, tile_aborted=1 at tile_done. abort in IDLE/CHECK/DRAIN ignored except it sets tile_aborted if seen in DRAIN before tile_done.

Reset
REQ-036 On m_axi_aresetn low, immediately: state IDLE, cmd_valid 0, busy 0, tile_done 0, tile_aborted 0, cfg_err 0, outstanding 0, tile_ready 0 while reset low, 1 after release; mid-tile progress discarded.
REQ-037 cmd_size = log2(BEAT_BYTES) at all times including reset; cmd_addr, cmd_len, cmd_last reset to 0.

Verification
REQ-038 base 0x1000, row_bytes 2048, rows 1, cmd_ready=1 -> one cmd addr 0x1000 len 255 last 1; tile_done after one burst_done.
REQ-039 base 0x0F80, row_bytes 512, rows 1 -> cmd 0x0F80 len 15, then 0x1000 len 47 last 1.
REQ-040 base 0x2000, row_bytes 64, rows 3, stride 0x400 -> cmds 0x2000/0x2400/0x2800 len 7; cmd_last only on third.
REQ-041 MAX_OUTSTANDING 2, burst_done withheld, 4-burst tile -> 2 handshakes then cmd_valid low until burst_done; simultaneous handshake+burst_done keeps count.
REQ-042 abort after 1st handshake of 3-row tile, cmd_ready low -> no further cmd_valid; after burst_done, tile_done with tile_aborted 1.
REQ-043 row_bytes 12 -> cfg_err pulse, no cmd_valid, tile_ready 1 within 2 cycles; reset mid-tile -> outputs per REQ-036 asynchronously.

Source files
------------

// File: rtl/dma_tile_sequencer_if.sv
// Tile descriptor, burst command and completion signals between a tile
// sequencer (master side) and its producer/DMA environment (slave side).
interface dma_tile_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  tile_valid;
    logic                  tile_ready;
    logic [ADDR_WIDTH-1:0] tile_base;
    logic [15:0]           tile_row_bytes;
    logic [15:0]           tile_rows;
    logic [ADDR_WIDTH-1:0] tile_stride;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic [2:0]            cmd_size;
    logic                  cmd_last;

    logic                  burst_done;
    logic                  abort;
    logic                  busy;
    logic                  tile_done;
    logic                  tile_aborted;
    logic                  cfg_err;

    // Sequencer side: accepts descriptors, issues burst commands.
    modport master (
        input  tile_valid, tile_base, tile_row_bytes, tile_rows, tile_stride,
        input  cmd_ready, burst_done, abort,
        output tile_ready, cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_last,
        output busy, tile_done, tile_aborted, cfg_err
    );

    // Environment side: supplies descriptors, consumes commands.
    modport slave (
        output tile_valid, tile_base, tile_row_bytes, tile_rows, tile_stride,
        output cmd_ready, burst_done, abort,
        input  tile_ready, cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_last,
        input  busy, tile_done, tile_aborted, cfg_err
    );
endinterface

// File: rtl/dma_tile_sequencer.sv
// Splits a 2-D tile (rows x row_bytes, row pitch = stride) into AXI4 read
// burst commands of at most 256 beats that never cross a 4 KB boundary,
// with a cap on issued-but-incomplete bursts and abort support.
module dma_tile_sequencer #(
    parameter int unsigned DMA_AXI_ADDR_WIDTH = 32,
    parameter int unsigned DMA_DATA_WIDTH_SRC = 64,
    parameter int unsigned MAX_OUTSTANDING    = 4
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_aresetn,
    dma_tile_sequencer_if.master    bus
);
    localparam int unsigned AW         = DMA_AXI_ADDR_WIDTH;
    localparam int unsigned BEAT_BYTES = DMA_DATA_WIDTH_SRC / 8;
    localparam int unsigned SIZE       = $clog2(BEAT_BYTES);
    localparam int unsigned OW         = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [2:0]    CMD_SIZE  = 3'(SIZE);
    localparam logic [15:0]   ROW_MASK  = 16'(BEAT_BYTES - 1);
    localparam logic [AW-1:0] ADDR_MASK = AW'(BEAT_BYTES - 1);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DRAIN} state_t;

    state_t          state;
    logic [AW-1:0]   row_start;
    logic [AW-1:0]   cur_addr;
    logic [AW-1:0]   stride_q;
    logic [15:0]     row_bytes_q;
    logic [15:0]     rem_bytes;
    logic [15:0]     rows_left;
    logic [OW-1:0]   outstanding;
    logic            abort_seen;

    logic            tile_ready_q;
    logic            cmd_valid_q;
    logic [AW-1:0]   cmd_addr_q;
    logic [7:0]      cmd_len_q;
    logic            cmd_last_q;
    logic            busy_q;
    logic            tile_done_q;
    logic            tile_aborted_q;
    logic            cfg_err_q;

    logic            hs_c;
    logic            dec_c;
    logic [OW-1:0]   out_next_c;
    logic            abort_c;
    logic            desc_ok_c;
    logic [12:0]     bound_bytes_c;
    logic [12:0]     bound_beats_c;
    logic [15:0]     rem_beats_c;
    logic [15:0]     beats_c;
    logic [15:0]     burst_bytes_c;
    logic            row_end_c;
    logic            last_c;
    logic [AW-1:0]   next_row_c;
    logic            load_c;

    // Next-burst geometry, outstanding bookkeeping and command-load decision.
    always_comb begin
        hs_c          = cmd_valid_q & bus.cmd_ready;
        dec_c         = bus.burst_done && (outstanding != '0);
        out_next_c    = outstanding;
        if (hs_c && !dec_c) begin
            out_next_c = outstanding + OW'(1);
        end else if (!hs_c && dec_c) begin
            out_next_c = outstanding - OW'(1);
        end
        abort_c       = bus.abort | abort_seen;
        desc_ok_c     = (row_bytes_q != 16'd0) && (rows_left != 16'd0) &&
                        ((row_bytes_q & ROW_MASK) == 16'd0) &&
                        ((cur_addr & ADDR_MASK) == '0);
        bound_bytes_c = 13'd4096 - {1'b0, cur_addr[11:0]};
        bound_beats_c = bound_bytes_c >> SIZE;
        rem_beats_c   = rem_bytes >> SIZE;
        beats_c       = 16'd256;
        if (16'(bound_beats_c) < beats_c) begin
            beats_c = 16'(bound_beats_c);
        end
        if (rem_beats_c < beats_c) begin
            beats_c = rem_beats_c;
        end
        burst_bytes_c = beats_c << SIZE;
        row_end_c     = (rem_bytes == burst_bytes_c);
        last_c        = row_end_c && (rows_left == 16'd1);
        next_row_c    = row_start + stride_q;
        load_c        = 1'b0;
        if (state == CHECK) begin
            load_c = desc_ok_c;
        end else if (state == ISSUE) begin
            load_c = !abort_c && (out_next_c < OUT_MAX) &&
                     (!cmd_valid_q || (hs_c && !cmd_last_q));
        end
    end

    // Sequencer FSM, cursor advance and registered outputs.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state          <= IDLE;
            row_start      <= '0;
            cur_addr       <= '0;
            stride_q       <= '0;
            row_bytes_q    <= '0;
            rem_bytes      <= '0;
            rows_left      <= '0;
            outstanding    <= '0;
            abort_seen     <= 1'b0;
            tile_ready_q   <= 1'b0;
            cmd_valid_q    <= 1'b0;
            cmd_addr_q     <= '0;
            cmd_len_q      <= '0;
            cmd_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            tile_done_q    <= 1'b0;
            tile_aborted_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            tile_done_q    <= 1'b0;
            tile_aborted_q <= 1'b0;
            cfg_err_q      <= 1'b0;
            outstanding    <= out_next_c;

            if (load_c) begin
                cmd_addr_q <= cur_addr;
                cmd_len_q  <= 8'(beats_c - 16'd1);
                cmd_last_q <= last_c;
                if (row_end_c) begin
                    row_start <= next_row_c;
                    cur_addr  <= next_row_c;
                    rem_bytes <= row_bytes_q;
                    rows_left <= rows_left - 16'd1;
                end else begin
                    cur_addr  <= cur_addr + AW'(burst_bytes_c);
                    rem_bytes <= rem_bytes - burst_bytes_c;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.tile_valid && tile_ready_q) begin
                        state        <= CHECK;
                        tile_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        abort_seen   <= 1'b0;
                        row_start    <= bus.tile_base;
                        cur_addr     <= bus.tile_base;
                        stride_q     <= bus.tile_stride;
                        row_bytes_q  <= bus.tile_row_bytes;
                        rem_bytes    <= bus.tile_row_bytes;
                        rows_left    <= bus.tile_rows;
                    end else begin
                        tile_ready_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (desc_ok_c) begin
                        state       <= ISSUE;
                        cmd_valid_q <= 1'b1;
                    end else begin
                        state        <= IDLE;
                        cfg_err_q    <= 1'b1;
                        busy_q       <= 1'b0;
                        tile_ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.abort) begin
                        abort_seen <= 1'b1;
                    end
                    if (hs_c && (cmd_last_q || abort_c)) begin
                        state       <= DRAIN;
                        cmd_valid_q <= 1'b0;
                    end else if (!cmd_valid_q && abort_c) begin
                        state <= DRAIN;
                    end else if (!cmd_valid_q || hs_c) begin
                        cmd_valid_q <= load_c;
                    end
                end
                DRAIN: begin
                    if (bus.abort) begin
                        abort_seen <= 1'b1;
                    end
                    if (outstanding == '0) begin
                        state          <= IDLE;
                        tile_done_q    <= 1'b1;
                        tile_aborted_q <= abort_seen | bus.abort;
                        busy_q         <= 1'b0;
                        tile_ready_q   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tile_ready   = tile_ready_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_addr     = cmd_addr_q;
    assign bus.cmd_len      = cmd_len_q;
    assign bus.cmd_size     = CMD_SIZE;
    assign bus.cmd_last     = cmd_last_q;
    assign bus.busy         = busy_q;
    assign bus.tile_done    = tile_done_q;
    assign bus.tile_aborted = tile_aborted_q;
    assign bus.cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_dma_tile_sequencer.sv
// Directed bench for dma_tile_sequencer (64-bit beats, MAX_OUTSTANDING = 2).
module tb_dma_tile_sequencer;
    localparam int unsigned AW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_tile_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    dma_tile_sequencer #(
        .DMA_AXI_ADDR_WIDTH (AW),
        .DMA_DATA_WIDTH_SRC (64),
        .MAX_OUTSTANDING    (2)
    ) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .bus           (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Command/handshake recorder and hold-stability watcher.
    int hs_cnt = 0, done_cnt = 0, abt_cnt = 0, cfg_cnt = 0, cv_cnt = 0, stab_err = 0;
    logic [31:0] q_addr[$];
    logic [7:0]  q_len[$];
    logic        q_last[$];
    logic        pend = 1'b0;
    logic [31:0] p_addr = '0;
    logic [7:0]  p_len = '0;
    logic        p_last = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (bus.cmd_valid) cv_cnt++;
            if (pend && !(bus.cmd_valid && bus.cmd_addr == p_addr &&
                          bus.cmd_len == p_len && bus.cmd_last == p_last)) stab_err++;
            pend   = bus.cmd_valid && !bus.cmd_ready;
            p_addr = bus.cmd_addr;
            p_len  = bus.cmd_len;
            p_last = bus.cmd_last;
            if (bus.cmd_valid && bus.cmd_ready) begin
                hs_cnt++;
                q_addr.push_back(bus.cmd_addr);
                q_len.push_back(bus.cmd_len);
                q_last.push_back(bus.cmd_last);
            end
            if (bus.tile_done) begin
                done_cnt++;
                if (bus.tile_aborted) abt_cnt++;
            end
            if (bus.cfg_err) cfg_cnt++;
        end
    end

    task automatic send_desc(input logic [31:0] base, input logic [15:0] rb,
                             input logic [15:0] rows, input logic [31:0] stride);
        bit ok = 1'b0;
        @(negedge clk);
        bus.tile_base      = base;
        bus.tile_row_bytes = rb;
        bus.tile_rows      = rows;
        bus.tile_stride    = stride;
        bus.tile_valid     = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.tile_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("desc_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.tile_valid = 1'b0;
    endtask

    // Runs a tile with cmd_ready high, returning one burst_done per handshake.
    task automatic run_tile(input logic [31:0] base, input logic [15:0] rb,
                            input logic [15:0] rows, input logic [31:0] stride);
        int h0 = hs_cnt;
        int d0 = done_cnt;
        int sent = 0;
        send_desc(base, rb, rows, stride);
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > d0) break;
            bus.burst_done = (hs_cnt - h0 > sent);
            if (bus.burst_done) sent++;
            @(negedge clk);
        end
        bus.burst_done = 1'b0;
        bus.cmd_ready  = 1'b0;
        chk("tile_done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_cmd(input string tag, input int idx, input logic [31:0] addr,
                             input logic [7:0] len, input logic last);
        if (idx >= q_addr.size()) begin
            chk({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_addr"}, 64'(q_addr[idx]), 64'(addr));
            chk({tag, "_len"},  64'(q_len[idx]),  64'(len));
            chk({tag, "_last"}, 64'(q_last[idx]), 64'(last));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h0, d0, a0, c0, v0;
        logic [31:0] bad_base[4];
        logic [15:0] bad_rb[4];
        logic [15:0] bad_rows[4];

        bus.tile_valid = 1'b0;
        bus.tile_base = '0;
        bus.tile_row_bytes = '0;
        bus.tile_rows = '0;
        bus.tile_stride = '0;
        bus.cmd_ready = 1'b0;
        bus.burst_done = 1'b0;
        bus.abort = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tile_ready", 64'(bus.tile_ready), 64'd0);
        chk("rst_cmd_valid",  64'(bus.cmd_valid),  64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        chk("rst_cmd_size",   64'(bus.cmd_size),   64'd3);
        chk("rst_cmd_addr",   64'(bus.cmd_addr),   64'd0);
        chk("rst_cmd_len",    64'(bus.cmd_len),    64'd0);
        chk("rst_cmd_last",   64'(bus.cmd_last),   64'd0);
        chk("rst_tile_done",  64'(bus.tile_done),  64'd0);
        chk("rst_cfg_err",    64'(bus.cfg_err),    64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_tile_ready", 64'(bus.tile_ready), 64'd1);

        // One full 256-beat burst
        h0 = hs_cnt; a0 = abt_cnt;
        run_tile(32'h1000, 16'd2048, 16'd1, 32'h0);
        chk("t1_ncmd", 64'(hs_cnt - h0), 64'd1);
        check_cmd("t1_c0", h0, 32'h1000, 8'd255, 1'b1);
        chk("t1_not_aborted", 64'(abt_cnt - a0), 64'd0);

        // 4 KB split
        h0 = hs_cnt;
        run_tile(32'h0F80, 16'd512, 16'd1, 32'h0);
        chk("t2_ncmd", 64'(hs_cnt - h0), 64'd2);
        check_cmd("t2_c0", h0,     32'h0F80, 8'd15, 1'b0);
        check_cmd("t2_c1", h0 + 1, 32'h1000, 8'd47, 1'b1);

        // Strided rows
        h0 = hs_cnt;
        run_tile(32'h2000, 16'd64, 16'd3, 32'h400);
        chk("t3_ncmd", 64'(hs_cnt - h0), 64'd3);
        check_cmd("t3_c0", h0,     32'h2000, 8'd7, 1'b0);
        check_cmd("t3_c1", h0 + 1, 32'h2400, 8'd7, 1'b0);
        check_cmd("t3_c2", h0 + 2, 32'h2800, 8'd7, 1'b1);

        // 256-beat cap inside one 4 KB page
        h0 = hs_cnt;
        run_tile(32'h0, 16'd4096, 16'd1, 32'h0);
        chk("t4_ncmd", 64'(hs_cnt - h0), 64'd2);
        check_cmd("t4_c0", h0,     32'h0,   8'd255, 1'b0);
        check_cmd("t4_c1", h0 + 1, 32'h800, 8'd255, 1'b1);

        // Row address wraps modulo 2^32
        h0 = hs_cnt;
        run_tile(32'hFFFF_FFC0, 16'd64, 16'd2, 32'h80);
        chk("t5_ncmd", 64'(hs_cnt - h0), 64'd2);
        check_cmd("t5_c0", h0,     32'hFFFF_FFC0, 8'd7, 1'b0);
        check_cmd("t5_c1", h0 + 1, 32'h0000_0040, 8'd7, 1'b1);

        // Outstanding limit of 2 with burst_done withheld
        h0 = hs_cnt; d0 = done_cnt;
        send_desc(32'h3000, 16'd64, 16'd4, 32'h40);
        chk("t6_busy", 64'(bus.busy), 64'd1);
        bus.cmd_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_hs_at_limit", 64'(hs_cnt - h0), 64'd2);
        chk("t6_valid_at_limit", 64'(bus.cmd_valid), 64'd0);
        bus.cmd_ready = 1'b0;
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        @(negedge clk);
        chk("t6_valid_after_done", 64'(bus.cmd_valid), 64'd1);
        bus.cmd_ready = 1'b1;
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        chk("t6_hs3", 64'(hs_cnt - h0), 64'd3);
        chk("t6_valid_after_simul", 64'(bus.cmd_valid), 64'd1);
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        chk("t6_hs4", 64'(hs_cnt - h0), 64'd4);
        chk("t6_valid_drain", 64'(bus.cmd_valid), 64'd0);
        check_cmd("t6_c3", h0 + 3, 32'h30C0, 8'd7, 1'b1);
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_early_done", 64'(done_cnt - d0), 64'd0);
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        for (int i = 0; i < 10 && done_cnt == d0; i++) @(negedge clk);
        chk("t6_done", 64'(done_cnt - d0), 64'd1);

        // Abort with a command pending
        h0 = hs_cnt; d0 = done_cnt; a0 = abt_cnt;
        send_desc(32'h5000, 16'd64, 16'd3, 32'h100);
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 20 && hs_cnt == h0; i++) @(negedge clk);
        chk("t7_first_hs", 64'(hs_cnt - h0), 64'd1);
        bus.cmd_ready = 1'b0;
        bus.abort = 1'b1;
        repeat (4) @(negedge clk);
        chk("t7_pending_held", 64'(bus.cmd_valid), 64'd1);
        chk("t7_pending_addr", 64'(bus.cmd_addr), 64'h5100);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        bus.abort = 1'b0;
        v0 = cv_cnt;
        repeat (4) @(negedge clk);
        chk("t7_hs_total", 64'(hs_cnt - h0), 64'd2);
        chk("t7_no_new_valid", 64'(cv_cnt - v0), 64'd0);
        chk("t7_not_done_yet", 64'(done_cnt - d0), 64'd0);
        check_cmd("t7_c1", h0 + 1, 32'h5100, 8'd7, 1'b0);
        bus.burst_done = 1'b1;
        repeat (2) @(negedge clk);
        bus.burst_done = 1'b0;
        for (int i = 0; i < 10 && done_cnt == d0; i++) @(negedge clk);
        chk("t7_done", 64'(done_cnt - d0), 64'd1);
        chk("t7_aborted", 64'(abt_cnt - a0), 64'd1);

        // Rejected descriptors
        bad_base = '{32'h100, 32'h100, 32'h100, 32'h104};
        bad_rb   = '{16'd12, 16'd0, 16'd64, 16'd64};
        bad_rows = '{16'd1, 16'd1, 16'd0, 16'd1};
        for (int k = 0; k < 4; k++) begin
            c0 = cfg_cnt; h0 = hs_cnt; v0 = cv_cnt; d0 = done_cnt;
            send_desc(bad_base[k], bad_rb[k], bad_rows[k], 32'h0);
            @(negedge clk);
            chk($sformatf("cfg%0d_err_pulse", k), 64'(bus.cfg_err), 64'd1);
            chk($sformatf("cfg%0d_ready", k), 64'(bus.tile_ready), 64'd1);
            repeat (3) @(negedge clk);
            chk($sformatf("cfg%0d_err_count", k), 64'(cfg_cnt - c0), 64'd1);
            chk($sformatf("cfg%0d_no_valid", k), 64'(cv_cnt - v0), 64'd0);
            chk($sformatf("cfg%0d_no_cmd", k), 64'(hs_cnt - h0), 64'd0);
            chk($sformatf("cfg%0d_no_done", k), 64'(done_cnt - d0), 64'd0);
        end

        // Asynchronous reset mid-tile
        send_desc(32'h6000, 16'd64, 16'd2, 32'h40);
        repeat (2) @(negedge clk);
        chk("t9_valid_before", 64'(bus.cmd_valid), 64'd1);
        chk("t9_busy_before", 64'(bus.busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t9_rst_valid", 64'(bus.cmd_valid), 64'd0);
        chk("t9_rst_busy", 64'(bus.busy), 64'd0);
        chk("t9_rst_ready", 64'(bus.tile_ready), 64'd0);
        chk("t9_rst_addr", 64'(bus.cmd_addr), 64'd0);
        chk("t9_rst_last", 64'(bus.cmd_last), 64'd0);
        chk("t9_rst_size", 64'(bus.cmd_size), 64'd3);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        h0 = hs_cnt;
        run_tile(32'h7000, 16'd128, 16'd1, 32'h0);
        chk("t9_recover_ncmd", 64'(hs_cnt - h0), 64'd1);
        check_cmd("t9_c0", h0, 32'h7000, 8'd15, 1'b1);

        chk("cmd_hold_stable", 64'(stab_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
